// File: rtl/stack_ctl.sv
// Stack sequencing/monitoring controller between the J1 core and one stack2 instance.
// Passes core ops through in RUN; a debug host can halt and run peek/pop/push/clear.
module stack_ctl #(
  parameter int DEPTH = 16,
  parameter int HIWAT = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_delta,
  input  logic [15:0] cpu_wd,
  output logic        cpu_stall,
  output logic        stk_we,
  output logic [1:0]  stk_delta,
  output logic [15:0] stk_wd,
  input  logic [15:0] stk_rd,
  input  logic        dbg_hold,
  input  logic        dbg_strobe,
  input  logic [1:0]  dbg_op,
  input  logic [15:0] dbg_wd,
  output logic        dbg_ack,
  output logic [15:0] dbg_rd,
  output logic [$clog2(DEPTH+2)-1:0] depth,
  output logic        overflow,
  output logic        underflow,
  output logic        hi_water,
  output logic [1:0]  fsm_state
);

  localparam int DW = $clog2(DEPTH+2);
  localparam logic [DW-1:0] FULL = DW'(DEPTH + 1);

  localparam logic [1:0] OP_PEEK  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_PUSH  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    S_RUN  = 2'b00,
    S_HALT = 2'b01,
    S_OP   = 2'b10,
    S_ACK  = 2'b11
  } state_t;

  state_t      state, state_nx;
  logic [1:0]  op_q;
  logic [15:0] wd_q;
  logic        eff_push, eff_pop;

  // Debug handshake: dbg_strobe is a one-cycle request taken only in HALT;
  // dbg_ack is a one-cycle completion pulse two cycles later, with dbg_rd valid from then on.
  always_comb begin
    state_nx  = state;
    stk_we    = 1'b0;
    stk_delta = 2'b00;
    stk_wd    = wd_q;
    case (state)
      S_RUN: begin
        stk_we    = cpu_we;
        stk_delta = cpu_delta;
        stk_wd    = cpu_wd;
        if (dbg_hold) state_nx = S_HALT;
      end
      S_HALT: begin
        if (dbg_strobe)     state_nx = S_OP;
        else if (!dbg_hold) state_nx = S_RUN;
      end
      S_OP: begin
        if (op_q == OP_POP) begin
          stk_delta = 2'b11;
        end else if (op_q == OP_PUSH) begin
          stk_we    = 1'b1;
          stk_delta = 2'b01;
        end
        state_nx = S_ACK;
      end
      S_ACK: state_nx = dbg_hold ? S_HALT : S_RUN;
      default: state_nx = S_RUN;
    endcase
    // Reset must not let a pass-through or debug op reach the stack.
    if (reset) begin
      stk_we    = 1'b0;
      stk_delta = 2'b00;
    end
  end

  assign eff_push = stk_we & stk_delta[0] & ~stk_delta[1];
  assign eff_pop  = stk_delta[0] & stk_delta[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_RUN;
      op_q      <= 2'b00;
      wd_q      <= 16'h0000;
      dbg_rd    <= 16'h0000;
      depth     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_HALT && dbg_strobe) begin
        op_q <= dbg_op;
        wd_q <= dbg_wd;
      end
      if (state == S_OP && (op_q == OP_PEEK || op_q == OP_POP))
        dbg_rd <= stk_rd;
      if (state == S_OP && op_q == OP_CLEAR) begin
        depth     <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else if (eff_push) begin
        // Full stack still takes the push; the bottom entry is lost.
        if (depth == FULL) overflow <= 1'b1;
        else               depth    <= depth + 1'b1;
      end else if (eff_pop) begin
        if (depth == '0) underflow <= 1'b1;
        else             depth     <= depth - 1'b1;
      end
    end
  end

  assign cpu_stall = (state != S_RUN);
  assign dbg_ack   = (state == S_ACK);
  assign hi_water  = (depth >= DW'(HIWAT));
  assign fsm_state = state;

endmodule

// File: tb/tb_stack_ctl.sv
// Directed bench for stack_ctl: a stack2 stand-in, a spec-level reference model
// checked every cycle, and hand-computed literal checks for the test-plan scenarios.
module tb_stack_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_we;
  logic [1:0]  cpu_delta;
  logic [15:0] cpu_wd;
  logic        cpu_stall;
  logic        stk_we;
  logic [1:0]  stk_delta;
  logic [15:0] stk_wd;
  logic [15:0] stk_rd;
  logic        dbg_hold;
  logic        dbg_strobe;
  logic [1:0]  dbg_op;
  logic [15:0] dbg_wd;
  logic        dbg_ack;
  logic [15:0] dbg_rd;
  logic [4:0]  depth;
  logic        overflow;
  logic        underflow;
  logic        hi_water;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;

  stack_ctl #(.DEPTH(16), .HIWAT(14)) dut (
    .clk(clk), .reset(reset),
    .cpu_we(cpu_we), .cpu_delta(cpu_delta), .cpu_wd(cpu_wd), .cpu_stall(cpu_stall),
    .stk_we(stk_we), .stk_delta(stk_delta), .stk_wd(stk_wd), .stk_rd(stk_rd),
    .dbg_hold(dbg_hold), .dbg_strobe(dbg_strobe), .dbg_op(dbg_op), .dbg_wd(dbg_wd),
    .dbg_ack(dbg_ack), .dbg_rd(dbg_rd), .depth(depth),
    .overflow(overflow), .underflow(underflow), .hi_water(hi_water), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- stack2 stand-in, driven by the DUT's stk_* ----------------
  logic [15:0] stk_q[$];
  logic [15:0] stk_head = 16'h0000;
  assign stk_rd = stk_head;

  // ---------------- reference model ----------------
  localparam int P_RUN = 0, P_HALT = 1, P_OP = 2, P_ACK = 3;
  int          m_phase = P_RUN;
  int          m_depth = 0;
  bit          m_ovf = 0, m_unf = 0;
  logic [15:0] m_rd = 16'h0000;
  logic [1:0]  m_op = 2'b00;
  logic [15:0] m_wd = 16'h0000;
  bit          chk_en = 0;

  // Expected stack drive from the current mode and inputs.
  task automatic exp_drive(output logic we, output logic [1:0] dl, output logic [15:0] wd);
    we = 1'b0; dl = 2'b00; wd = 16'h0000;
    if (!reset) begin
      if (m_phase == P_RUN) begin
        we = cpu_we; dl = cpu_delta; wd = cpu_wd;
      end else if (m_phase == P_OP && m_op == 2'b01) begin
        dl = 2'b11;
      end else if (m_phase == P_OP && m_op == 2'b10) begin
        we = 1'b1; dl = 2'b01; wd = m_wd;
      end
    end
  endtask

  always @(posedge clk) begin
    logic        e_we;
    logic [1:0]  e_dl;
    logic [15:0] e_wd;
    logic [15:0] head_now;
    head_now = stk_head;
    if (reset) begin
      m_phase = P_RUN; m_depth = 0; m_ovf = 0; m_unf = 0;
      m_rd = 16'h0000; m_op = 2'b00; m_wd = 16'h0000;
      chk_en = 1;
    end else begin
      exp_drive(e_we, e_dl, e_wd);
      if (m_phase == P_OP && m_op == 2'b11) begin
        m_depth = 0; m_ovf = 0; m_unf = 0;
      end else if (e_we && e_dl == 2'b01) begin
        if (m_depth == 17) m_ovf = 1; else m_depth = m_depth + 1;
      end else if (e_dl == 2'b11) begin
        if (m_depth == 0) m_unf = 1; else m_depth = m_depth - 1;
      end
      if (m_phase == P_OP && m_op != 2'b10 && m_op != 2'b11) m_rd = head_now;
      case (m_phase)
        P_RUN:  if (dbg_hold) m_phase = P_HALT;
        P_HALT: if (dbg_strobe) begin
                  m_op = dbg_op; m_wd = dbg_wd; m_phase = P_OP;
                end else if (!dbg_hold) m_phase = P_RUN;
        P_OP:   m_phase = P_ACK;
        default: m_phase = dbg_hold ? P_HALT : P_RUN;
      endcase
    end
    // stack2 behaviour on whatever the DUT actually drives
    if (stk_delta == 2'b01) begin
      stk_q.push_back(stk_we ? stk_wd : head_now);
      if (stk_q.size() > 17) stk_q.delete(0);
    end else if (stk_delta == 2'b11) begin
      if (stk_q.size() > 0) void'(stk_q.pop_back());
      if (stk_we && stk_q.size() > 0) stk_q[stk_q.size()-1] = stk_wd;
    end else if (stk_we && stk_q.size() > 0) begin
      stk_q[stk_q.size()-1] = stk_wd;
    end
    stk_head <= (stk_q.size() > 0) ? stk_q[stk_q.size()-1] : 16'h0000;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    logic        e_we;
    logic [1:0]  e_dl;
    logic [15:0] e_wd;
    if (chk_en) begin
      exp_drive(e_we, e_dl, e_wd);
      check("m_stk_we", stk_we, e_we);
      check("m_stk_delta", stk_delta, e_dl);
      if (e_we) check("m_stk_wd", stk_wd, e_wd);
      check("m_cpu_stall", cpu_stall, m_phase != P_RUN);
      check("m_dbg_ack", dbg_ack, m_phase == P_ACK);
      check("m_dbg_rd", dbg_rd, m_rd);
      check("m_depth", depth, m_depth);
      check("m_overflow", overflow, m_ovf);
      check("m_underflow", underflow, m_unf);
      check("m_hi_water", hi_water, m_depth >= 14);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic core_op(input logic we, input logic [1:0] dl, input logic [15:0] wd);
    cpu_we = we; cpu_delta = dl; cpu_wd = wd;
    cyc(1);
    cpu_we = 1'b0; cpu_delta = 2'b00; cpu_wd = 16'h0000;
  endtask

  // Issues one debug transaction from HALT and leaves the bench in the ACK cycle.
  task automatic dbg_to_ack(input logic [1:0] op, input logic [15:0] wd);
    dbg_strobe = 1'b1; dbg_op = op; dbg_wd = wd;
    cyc(1);
    dbg_strobe = 1'b0; dbg_op = 2'b00; dbg_wd = 16'h0000;
    cyc(1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1; cpu_we = 1'b0; cpu_delta = 2'b00; cpu_wd = 16'h0000;
    dbg_hold = 1'b0; dbg_strobe = 1'b0; dbg_op = 2'b00; dbg_wd = 16'h0000;
    cpu_we = 1'b1; cpu_delta = 2'b01; cpu_wd = 16'h5555;
    cyc(1);
    check("reset_gates_we", stk_we, 1'b0);
    check("reset_gates_delta", stk_delta, 2'b00);
    cpu_we = 1'b0; cpu_delta = 2'b00; cpu_wd = 16'h0000;
    cyc(1);
    reset = 1'b0;
    check("reset_depth", depth, 5'd0);
    check("reset_flags", {overflow, underflow, dbg_ack, cpu_stall}, 4'b0000);
    check("reset_dbg_rd", dbg_rd, 16'h0000);

    // fill to capacity
    for (int i = 1; i <= 17; i++) begin
      core_op(1'b1, 2'b01, 16'(i));
      if (i == 13) check("hiwat_below", hi_water, 1'b0);
      if (i == 14) check("hiwat_at", hi_water, 1'b1);
    end
    check("full_depth", depth, 5'd17);
    check("full_no_ovf", overflow, 1'b0);
    check("full_hiwat", hi_water, 1'b1);
    core_op(1'b1, 2'b01, 16'h0012);
    check("ovf_depth", depth, 5'd17);
    check("ovf_flag", overflow, 1'b1);

    // clear, then underflow from empty, then clear again
    dbg_hold = 1'b1; cyc(1);
    check("halt_stall", cpu_stall, 1'b1);
    dbg_to_ack(2'b11, 16'h0000);
    check("clear_ack", dbg_ack, 1'b1);
    check("clear_depth", depth, 5'd0);
    dbg_hold = 1'b0; cyc(2);
    check("run_again", cpu_stall, 1'b0);
    core_op(1'b0, 2'b11, 16'h0000);
    check("unf_flag", underflow, 1'b1);
    check("unf_depth", depth, 5'd0);
    dbg_hold = 1'b1; cyc(1);
    dbg_to_ack(2'b11, 16'h0000);
    check("clear2_flags", {overflow, underflow}, 2'b00);
    dbg_hold = 1'b0; cyc(2);

    // peek / pop via debug
    core_op(1'b1, 2'b01, 16'hBEEF);
    core_op(1'b1, 2'b01, 16'h1234);
    dbg_hold = 1'b1; cyc(1);
    dbg_to_ack(2'b00, 16'h0000);
    check("peek_rd", dbg_rd, 16'h1234);
    check("peek_depth", depth, 5'd2);
    cyc(1);
    dbg_to_ack(2'b01, 16'h0000);
    check("pop1_rd", dbg_rd, 16'h1234);
    check("pop1_depth", depth, 5'd1);
    cyc(1);
    dbg_to_ack(2'b01, 16'h0000);
    check("pop2_rd", dbg_rd, 16'hBEEF);
    check("pop2_depth", depth, 5'd0);
    cyc(1);

    // debug push while the core requests a push
    cpu_we = 1'b1; cpu_delta = 2'b01; cpu_wd = 16'h0099;
    #2;
    check("halt_blocks_we", stk_we, 1'b0);
    dbg_strobe = 1'b1; dbg_op = 2'b10; dbg_wd = 16'hCAFE;
    cyc(1);
    dbg_strobe = 1'b0; dbg_op = 2'b00; dbg_wd = 16'h0000;
    check("push_op_wd", stk_wd, 16'hCAFE);
    check("push_op_we", {stk_we, stk_delta}, 3'b101);
    check("push_op_stall", cpu_stall, 1'b1);
    cyc(1);
    check("push_ack", dbg_ack, 1'b1);
    check("push_depth", depth, 5'd1);
    cyc(1);
    cpu_we = 1'b0; cpu_delta = 2'b00; cpu_wd = 16'h0000;
    dbg_hold = 1'b0;
    #2;
    check("stall_holds", cpu_stall, 1'b1);
    cyc(1);
    check("stall_falls", cpu_stall, 1'b0);

    // strobe in RUN is ignored
    dbg_strobe = 1'b1; dbg_op = 2'b01;
    cyc(1);
    dbg_strobe = 1'b0; dbg_op = 2'b00;
    for (int i = 0; i < 3; i++) begin
      check("run_strobe_noack", dbg_ack, 1'b0);
      cyc(1);
    end
    check("run_strobe_depth", depth, 5'd1);

    // strobe in ACK is ignored
    dbg_hold = 1'b1; cyc(1);
    dbg_to_ack(2'b00, 16'h0000);
    dbg_strobe = 1'b1; dbg_op = 2'b01;
    cyc(1);
    dbg_strobe = 1'b0; dbg_op = 2'b00;
    check("ack_strobe_noop", stk_delta, 2'b00);
    cyc(1);
    check("ack_strobe_noack", dbg_ack, 1'b0);
    check("ack_strobe_depth", depth, 5'd1);

    // reset during the OP cycle of a pop
    dbg_strobe = 1'b1; dbg_op = 2'b01;
    cyc(1);
    dbg_strobe = 1'b0; dbg_op = 2'b00;
    reset = 1'b1; dbg_hold = 1'b0;
    #1;
    check("rst_op_delta", stk_delta, 2'b00);
    cyc(1);
    reset = 1'b0;
    #1;
    check("rst_op_noack", dbg_ack, 1'b0);
    check("rst_op_run", cpu_stall, 1'b0);
    check("rst_op_depth", depth, 5'd0);
    cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_ctl.md
# stack_ctl

Sequencing and monitoring controller placed between the J1 core and one `stack2` instance (data or return stack). In normal running it passes core stack operations straight through with zero latency, tracks occupancy, and raises sticky overflow/underflow flags. A debug host can halt the core's access to the stack and run single-step peek/pop/push/clear transactions, so a monitor can dump or reload a stack without core involvement.

## Interface
- `DEPTH`, 16: tail depth of the attached `stack2`; total capacity is DEPTH+1 (head plus tail).
- `HIWAT`, 14: depth at or above which `hi_water` asserts.
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_we`, `cpu_delta`, `cpu_wd`  in  1/2/16  core stack request, in `stack2` encoding.
- `cpu_stall`  out  1  core must hold its stack request and not advance.
- `stk_we`, `stk_delta`, `stk_wd`  out  1/2/16  drive the `stack2` instance.
- `stk_rd`  in  1×16  `stack2` head value.
- `dbg_hold`  in  1  level; host requests ownership of the stack.
- `dbg_strobe`  in  1  one-cycle transaction start, honoured only in HALT.
- `dbg_op`  in  2  00 peek, 01 pop, 10 push, 11 clear.
- `dbg_wd`  in  16  push data.
- `dbg_ack`  out  1  one-cycle completion pulse.
- `dbg_rd`  out  16  head value captured by peek/pop.
- `depth`  out  5  current occupancy, 0..DEPTH+1.
- `overflow`, `underflow`, `hi_water`  out  1  sticky/derived status.

## Operation
- Delta encoding: `delta[0]`=move; with move, `delta[1]`=0 push, 1 pop. 2'b00 and 2'b10 are no-move.
- Effective op = (we & move & ~delta[1]) push; (move & delta[1]) pop (with `we`, a pop-and-replace: still counts as pop); otherwise no depth change.
- States: RUN, HALT, OP, ACK.
  - RUN: `stk_*` = `cpu_*` combinationally; `cpu_stall`=0. `dbg_hold`=1 -> HALT (the core op in this cycle still executes).
  - HALT: `stk_we`=0, `stk_delta`=00, `cpu_stall`=1. `dbg_strobe` -> latch `dbg_op`/`dbg_wd`, go OP. Else `dbg_hold`=0 -> RUN. Strobe has priority over hold release.
  - OP: issue the latched op for exactly one cycle: peek none; pop `stk_delta`=11, `stk_we`=0; push `stk_we`=1, `stk_delta`=01, `stk_wd`=latched data; clear no stack access. On the edge ending OP, `dbg_rd` <= `stk_rd` for peek/pop. -> ACK.
  - ACK: `dbg_ack`=1, no stack access; -> HALT if `dbg_hold`, else RUN.
- `dbg_strobe` outside HALT is ignored, with no latching.
- Depth: push increments, saturating at DEPTH+1. Push at DEPTH+1 is still forwarded (the bottom entry is lost) and sets `overflow`. Pop decrements, saturating at 0. Pop at 0 is still forwarded and sets `underflow`.
- Clear: `depth`<=0, `overflow`<=0, `underflow`<=0. The stack contents are not touched.
- `hi_water` = (`depth` >= HIWAT), combinational from the depth register.
- Flags stay set until reset or a clear op.

## Timing
- Reset values: state RUN, `depth` 0, `overflow`/`underflow` 0, `dbg_rd` 0, `dbg_ack` 0, latched op and data 0. While `reset`=1, `stk_we`=0 and `stk_delta`=00 regardless of the `cpu_*` inputs.
- Reset asserted in any state returns to RUN on the next edge. An OP cycle coincident with reset is suppressed, and no ack is issued.
- RUN pass-through is zero latency. `cpu_stall` is a registered Moore output (state != RUN) and rises on the cycle after `dbg_hold` is first sampled high.
- Debug transaction: strobe in HALT at cycle t -> OP at t+1 -> ACK at t+2, with `dbg_rd` valid from t+2 and held until the next peek/pop. The next strobe is accepted no earlier than t+3, in HALT.
- Depth and flags update on the same edge at which `stack2` commits the move.

## Test plan
- Reset, then 17 core pushes of 0x0001..0x0011 -> `depth`=17, `overflow`=0, `hi_water`=1 from `depth`=14. An 18th push -> `overflow`=1, `depth` stays 17.
- From empty, one core pop -> `underflow`=1, `depth`=0. A clear op then returns both flags to 0.
- Push 0xBEEF, 0x1234. Hold plus peek -> `dbg_rd`=0x1234 at the ack cycle, `depth`=2. Pop -> `dbg_rd`=0x1234, `depth`=1. A second pop -> `dbg_rd`=0xBEEF, `depth`=0.
- Hold, then push 0xCAFE via debug while `cpu_*` drives push 0x0099 -> `stk_wd`=0xCAFE only, the core op is not forwarded, `cpu_stall`=1 throughout, and it falls one cycle after hold drops.
- Strobe while in RUN or ACK -> ignored: no `dbg_ack`, depth unchanged.
- Assert reset during OP of a pop -> no `stk_delta` move, no ack, state RUN, `depth` 0.
